viterbi_decode9: RTL and testbench
==================================

# viterbi_decode9

Hard-decision Viterbi decoder for the constraint-length-9, rate-1/2 convolutional code produced by `viterbi_encode9`. It accepts one 2-bit code symbol per handshake and decodes a zero-terminated frame of `FRAME_LEN` information bits plus 8 tail bits. Add-compare-select (ACS) is serialized at one state per cycle over 256 states. After the last symbol, a full-frame traceback starting from state 0 emits the decoded bits in original order.

## Interface
- `FRAME_LEN`, 64: information bits per frame; frame length `L = FRAME_LEN + 8` symbols.
- `G_A`, 9'o561: generator for symbol bit 1; must equal the encoder's `wA` taps.
- `G_B`, 9'o753: generator for symbol bit 0; must equal the encoder's `wB` taps.
- `PM_W`, 12: path-metric width; requires `2*L < 2**(PM_W-1)`.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low.
- `Y` in 2: received code symbol `{A,B}`.
- `YValid` in 1: symbol valid.
- `YReady` out 1: decoder can accept a symbol.
- `X` out 1: decoded information bit.
- `XValid` out 1: `X` valid, one bit per cycle, no backpressure.
- `XLast` out 1: marks bit `FRAME_LEN-1`.
- `Metric` out PM_W: final path metric of state 0, i.e. the corrected-error count.

## Operation
- Encoder model:
  - State `s[7:0]` holds the previous 8 inputs, with `s[7]` the most recent.
  - For input `x`, the register is `r = {x,s}` and the expected symbol is `{^(r&G_A), ^(r&G_B)}`.
  - Next state is `{x, s[7:1]}`.
- Branch metric: Hamming distance between `Y` and the expected symbol, range 0..2.
- Predecessors of new state `n` are `{n[6:0],b}` for `b` in {0,1}; the input bit on both branches is `x = n[7]`.
- ACS for state `n`:
  - Form `m_b = pm_old[{n[6:0],b}] + bm_b` for each `b`.
  - Select `b=1` only if `m_1 < m_0`; on a tie, pick `b=0`.
  - Write the selected sum to `pm_new[n]` and store `surv[t][n] = b`.
- Path metrics live in ping-pong banks of 256 x PM_W, which swap after each symbol.
- Frame start initialization: `pm[0]=0`; all other states set to `INF = 2**(PM_W-1)`. No normalization or saturation is applied.
- Survivor memory: `L x 256` bits.
- FSM:
  - IDLE: initialize metrics; `YReady=1`; on accept, latch `Y`, set `t=0`, go to ACS.
  - ACS: runs 256 cycles for `n=0..255`, then does `t=t+1`. If `t<L` go to WAIT, otherwise go to TRACE.
  - WAIT: `YReady=1`; on accept, go to ACS.
  - TRACE: starts with `st=0` and `t=L-1` down to 0. Each step writes `obuf[t]=st[7]` when `t<FRAME_LEN`, then sets `st={st[6:0], surv[t][st]}`. Takes L cycles.
  - OUTPUT: emits `obuf[0..FRAME_LEN-1]` on consecutive cycles; returns to IDLE after `XLast`.
- Symbols presented while `YReady=0` are ignored; the source must hold `YValid`.

## Timing
- Reset values: `YReady=0`, `X=0`, `XValid=0`, `XLast=0`, `Metric=0`; FSM goes to IDLE.
- `YReady` rises in the first cycle after `Reset` deasserts.
- A symbol is accepted on the edge where `YValid&YReady`. `YReady` is 0 from the next cycle for exactly 256 cycles, then returns to 1.
- Symbol throughput is at most one per 257 cycles.
- After the L-th ACS completes: TRACE lasts L cycles, then `XValid` is high for exactly `FRAME_LEN` consecutive cycles.
- `XLast` is high only on the final bit.
- `Metric` is updated to `pm[0]` at TRACE entry and holds until the next frame's TRACE or reset.
- `X` is 0 whenever `XValid=0`.
- `YReady=0` throughout TRACE and OUTPUT. It is 1 in the cycle after `XLast`, and the next frame may start then.
- Reset asserted mid-ACS, mid-TRACE or mid-OUTPUT:
  - All outputs clear immediately and the partial frame is discarded.
  - The first frame accepted after release decodes correctly.

## Test plan
- **All-zero frame:** 72 symbols `00` -> 64 bits `0`, `XLast` on the 64th, `Metric=0`.
- **Impulse:** information bits 1 then 63 zeros, encoded by `viterbi_encode9` with 8 zero tail bits -> decoded 1 followed by 63 zeros, `Metric=0`. The first symbol must be `11`.
- **Error correction:** LFSR payload (x^7+x^6+1, seed 7'h01) with the `Y` bit-0 flipped at symbols 10, 30 and 50 -> exact payload, `Metric=3`.
- **Handshake:**
  - `YValid` with random 0-5 cycle gaps -> same output as gapless.
  - `YReady` low for exactly 256 cycles after each accept.
  - Exactly 72 accepts per frame.
- **Reset mid-frame:** `Reset` low for 2 cycles during ACS of symbol 20 -> all outputs 0. The next full encoded frame decodes exactly with `Metric=0`.
- **Back-to-back frames:** second frame starts the cycle after `XLast` -> both payloads exact. No `XValid` during the second frame's ACS.

Source files
------------

// File: rtl/viterbi_decode9.sv
// Hard-decision Viterbi decoder for the K=9, rate-1/2 code of viterbi_encode9.
// One ACS per cycle over 256 states, full-frame traceback from state 0.
module viterbi_decode9 #(
    parameter int         FRAME_LEN = 64,
    parameter logic [8:0] G_A       = 9'o561,
    parameter logic [8:0] G_B       = 9'o753,
    parameter int         PM_W      = 12
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [1:0]      Y,
    input  logic            YValid,
    output logic            YReady,
    output logic            X,
    output logic            XValid,
    output logic            XLast,
    output logic [PM_W-1:0] Metric
);

    localparam int L  = FRAME_LEN + 8;
    localparam int TW = $clog2(L);
    localparam int OW = $clog2(FRAME_LEN);

    localparam logic [TW-1:0]   T_LAST  = TW'(L - 1);
    localparam logic [TW-1:0]   T_FRAME = TW'(FRAME_LEN);
    localparam logic [OW-1:0]   O_LAST  = OW'(FRAME_LEN - 1);
    localparam logic [PM_W-1:0] INF     = {1'b1, {(PM_W-1){1'b0}}};
    // Frame start: state 0 is certain, every other state unreachable.
    localparam logic [255:0][PM_W-1:0] PM_INIT = {{255{INF}}, {PM_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACS,
        S_WAIT,
        S_TRACE,
        S_OUTPUT
    } state_t;

    function automatic logic [1:0] exp_sym(input logic [8:0] r);
        return {^(r & G_A), ^(r & G_B)};
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    state_t                  state_q, state_d;
    logic [7:0]              n_q, n_d;
    logic [TW-1:0]           t_q, t_d;
    logic [1:0]              y_q, y_d;
    logic                    cur_q, cur_d;
    logic [255:0]            row_q, row_d;
    logic [7:0]              st_q, st_d;
    logic [FRAME_LEN-1:0]    obuf_q, obuf_d;
    logic [OW-1:0]           oidx_q, oidx_d;
    logic                    yready_q, yready_d;
    logic [PM_W-1:0]         metric_q, metric_d;

    logic [1:0][255:0][PM_W-1:0] pm_mem;
    logic [255:0]                surv_mem [L];

    logic            accept;
    logic [7:0]      p0, p1;
    logic [1:0]      bm0, bm1;
    logic [PM_W-1:0] m0, m1, acs_pm;
    logic            sel;
    logic [255:0]    row_now;
    logic            pm_init, pm_we, surv_we;

    assign accept = YValid & yready_q;

    // Both predecessors of n share input bit n[7]; they differ only in the oldest bit.
    always_comb begin
        p0      = {n_q[6:0], 1'b0};
        p1      = {n_q[6:0], 1'b1};
        bm0     = hamming(y_q, exp_sym({n_q[7], p0}));
        bm1     = hamming(y_q, exp_sym({n_q[7], p1}));
        m0      = pm_mem[cur_q][p0] + {{(PM_W-2){1'b0}}, bm0};
        m1      = pm_mem[cur_q][p1] + {{(PM_W-2){1'b0}}, bm1};
        sel     = (m1 < m0);
        acs_pm  = sel ? m1 : m0;
        row_now = row_q;
        row_now[n_q] = sel;
    end

    assign pm_init = (state_q == S_IDLE);
    assign pm_we   = (state_q == S_ACS);
    assign surv_we = (state_q == S_ACS) && (n_q == 8'hFF);

    always_ff @(posedge Clock) begin
        if (pm_init) begin
            pm_mem[1'b0] <= PM_INIT;
        end else if (pm_we) begin
            pm_mem[~cur_q][n_q] <= acs_pm;
        end
        if (surv_we) begin
            surv_mem[t_q] <= row_now;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        t_d      = t_q;
        y_d      = y_q;
        cur_d    = cur_q;
        row_d    = row_q;
        st_d     = st_q;
        obuf_d   = obuf_q;
        oidx_d   = oidx_q;
        metric_d = metric_q;
        case (state_q)
            S_IDLE: begin
                cur_d = 1'b0;
                if (accept) begin
                    y_d     = Y;
                    t_d     = '0;
                    n_d     = '0;
                    state_d = S_ACS;
                end
            end
            S_ACS: begin
                row_d = row_now;
                n_d   = n_q + 8'd1;
                if (n_q == 8'hFF) begin
                    cur_d = ~cur_q;
                    if (t_q == T_LAST) begin
                        // State 0 of the new bank was written at n=0 of this pass.
                        metric_d = pm_mem[~cur_q][0];
                        st_d     = '0;
                        state_d  = S_TRACE;
                    end else begin
                        t_d     = t_q + TW'(1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (accept) begin
                    y_d     = Y;
                    n_d     = '0;
                    state_d = S_ACS;
                end
            end
            S_TRACE: begin
                if (t_q < T_FRAME) begin
                    obuf_d[t_q[OW-1:0]] = st_q[7];
                end
                st_d = {st_q[6:0], surv_mem[t_q][st_q]};
                if (t_q == '0) begin
                    oidx_d  = '0;
                    state_d = S_OUTPUT;
                end else begin
                    t_d = t_q - TW'(1);
                end
            end
            S_OUTPUT: begin
                oidx_d = oidx_q + OW'(1);
                if (oidx_q == O_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        yready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            t_q      <= '0;
            y_q      <= '0;
            cur_q    <= 1'b0;
            row_q    <= '0;
            st_q     <= '0;
            obuf_q   <= '0;
            oidx_q   <= '0;
            yready_q <= 1'b0;
            metric_q <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            t_q      <= t_d;
            y_q      <= y_d;
            cur_q    <= cur_d;
            row_q    <= row_d;
            st_q     <= st_d;
            obuf_q   <= obuf_d;
            oidx_q   <= oidx_d;
            yready_q <= yready_d;
            metric_q <= metric_d;
        end
    end

    assign YReady = yready_q;
    assign XValid = (state_q == S_OUTPUT);
    assign X      = XValid & obuf_q[oidx_q];
    assign XLast  = XValid && (oidx_q == O_LAST);
    assign Metric = metric_q;

endmodule

// File: tb/tb_viterbi_decode9.sv
// Bench for viterbi_decode9: encodes payloads, drives the handshake, and checks
// decoded bits, XLast, Metric and YReady timing against expectations.
module tb_viterbi_decode9;

    localparam int FL = 64;
    localparam int L  = FL + 8;
    localparam logic [8:0] GA = 9'o561;
    localparam logic [8:0] GB = 9'o753;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  Y = 2'b00;
    logic        YValid = 1'b0;
    logic        YReady, X, XValid, XLast;
    logic [11:0] Metric;

    always #5 Clock = ~Clock;

    viterbi_decode9 dut (
        .Clock (Clock),
        .Reset (Reset),
        .Y     (Y),
        .YValid(YValid),
        .YReady(YReady),
        .X     (X),
        .XValid(XValid),
        .XLast (XLast),
        .Metric(Metric)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tot = 0;
    int base = 0;
    int xlast_cyc = 0;
    int accepts = 0;
    int last_acc_cyc = 0;

    bit         pay[FL];
    bit         exp_bits[FL];
    logic [1:0] syms[L];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(posedge Clock) cyc <= cyc + 1;

    // Encoder model: state holds last 8 inputs, newest in bit 7.
    function automatic void encode_pay();
        logic [7:0] s;
        logic [8:0] r;
        logic       x;
        s = 8'h00;
        for (int i = 0; i < L; i++) begin
            x = (i < FL) ? pay[i] : 1'b0;
            r = {x, s};
            syms[i] = {^(r & GA), ^(r & GB)};
            s = {x, s[7:1]};
        end
    endfunction

    function automatic void set_zero();
        for (int i = 0; i < FL; i++) pay[i] = 1'b0;
    endfunction

    function automatic void set_impulse();
        for (int i = 0; i < FL; i++) pay[i] = (i == 0);
    endfunction

    function automatic void set_lfsr();
        logic [6:0] lf;
        lf = 7'h01;
        for (int i = 0; i < FL; i++) begin
            pay[i] = lf[6];
            lf = {lf[5:0], lf[6] ^ lf[5]};
        end
    endfunction

    // Output monitor: every bit in order, XLast on the last one, quiet otherwise.
    always @(negedge Clock) begin
        int idx;
        if (Reset) begin
            if (XValid) begin
                idx = tot - base;
                if (idx >= 0 && idx < FL) begin
                    chk("x_bit", X, exp_bits[idx]);
                    chk("x_last", XLast, (idx == FL - 1) ? 1 : 0);
                end else begin
                    chk("xvalid_unexpected", XValid, 0);
                end
                if (XLast) xlast_cyc = cyc;
                tot = tot + 1;
            end else begin
                chk("x_quiet", {XLast, X}, 0);
            end
        end
    end

    task automatic send_sym(input logic [1:0] s, input int gap, input bit hold, input bit last);
        int w;
        int cnt;
        w = 0;
        cnt = 0;
        YValid = 1'b0;
        repeat (gap) @(negedge Clock);
        Y = s;
        YValid = 1'b1;
        while (!YReady && w < 3000) begin
            @(negedge Clock);
            w++;
        end
        chk("yready_wait", YReady, 1);
        @(posedge Clock);
        accepts++;
        #1;
        last_acc_cyc = cyc;
        if (hold && !last) Y = ~s;
        else YValid = 1'b0;
        if (!last) begin
            @(negedge Clock);
            while (!YReady && cnt < 400) begin
                cnt++;
                @(negedge Clock);
            end
            chk("yready_low_cycles", cnt, 256);
        end
    endtask

    task automatic run_frame(input string nm, input int maxgap, input bit hold,
                             input int f0, input int f1, input int f2,
                             input int exp_metric, input bit b2b);
        logic [1:0] s;
        int w;
        int first_acc;
        encode_pay();
        for (int i = 0; i < FL; i++) exp_bits[i] = pay[i];
        base = tot;
        accepts = 0;
        first_acc = 0;
        for (int i = 0; i < L; i++) begin
            s = syms[i];
            if (i == f0 || i == f1 || i == f2) s[0] = ~s[0];
            send_sym(s, $urandom_range(maxgap, 0), hold, i == L - 1);
            if (i == 0) first_acc = last_acc_cyc;
        end
        if (b2b) chk({nm, "_start_after_xlast"}, first_acc - xlast_cyc, 2);
        chk({nm, "_accepts"}, accepts, L);
        w = 0;
        while (tot < base + FL && w < 2000) begin
            @(negedge Clock);
            w++;
        end
        chk({nm, "_bits"}, tot - base, FL);
        chk({nm, "_metric"}, Metric, exp_metric);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_yready"}, YReady, 0);
        chk({nm, "_x"}, X, 0);
        chk({nm, "_xvalid"}, XValid, 0);
        chk({nm, "_xlast"}, XLast, 0);
        chk({nm, "_metric"}, Metric, 0);
    endtask

    initial begin
        repeat (3) @(negedge Clock);
        chk_all_zero("reset");
        Reset = 1'b1;
        @(negedge Clock);
        chk("yready_rise", YReady, 1);

        // Hand-derived anchors for the model itself.
        set_impulse();
        encode_pay();
        chk("enc_impulse_sym0", syms[0], 2'b11);
        chk("enc_impulse_sym1", syms[1], 2'b01);
        set_lfsr();
        chk("lfsr_bit5", pay[5], 0);
        chk("lfsr_bit6", pay[6], 1);

        set_zero();
        run_frame("zero", 0, 1'b0, -1, -1, -1, 0, 1'b0);

        set_lfsr();
        run_frame("errcorr", 5, 1'b0, 10, 30, 50, 3, 1'b0);

        // Partial frame cut by reset during ACS of symbol 20.
        set_impulse();
        encode_pay();
        base = tot - FL;
        for (int i = 0; i <= 20; i++) send_sym(syms[i], 0, 1'b0, i == 20);
        repeat (40) @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge Clock);
        chk_all_zero("midreset_hold");
        Reset = 1'b1;
        @(negedge Clock);
        chk("yready_after_midreset", YReady, 1);

        set_impulse();
        run_frame("impulse", 0, 1'b1, -1, -1, -1, 0, 1'b0);

        set_lfsr();
        run_frame("b2b_lfsr", 0, 1'b0, -1, -1, -1, 0, 1'b1);

        repeat (5) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (95000) @(posedge Clock);
        $display("FAIL watchdog cycles=%0d limit=%0d", cyc, 95000);
        $fatal(1, "bench timed out");
    end

endmodule
